// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel datapath. A block is latched in
// IDLE, RPC rounds are applied per RUN cycle using subkeys supplied by an
// external key schedule (indexed through key_idx), and the result is held
// in DONE until the consumer takes it.
module des_round_engine #(
    parameter int ROUNDS = 16,
    parameter int RPC    = 1,
    parameter int USE_IP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_block,
    input  logic              in_decrypt,
    output logic [3:0]        key_idx,
    input  logic [48*RPC-1:0] subkey,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_block,
    output logic              busy
);

    // S-boxes S1..S8; entry (row*16+col) is the nibble at position
    // row*16+col counted from the most significant end.
    localparam logic [255:0] S_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // P permutation, DES bit numbering (1 = MSB).
    localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                  2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam logic [4:0] RPC5    = 5'(RPC);
    localparam logic [4:0] ROUNDS5 = 5'(ROUNDS);

    // IP has a regular structure: output row r, column c takes DES bit
    // 8*(7-c) + base(r), with base = 2,4,6,8,1,3,5,7.
    function automatic int ip_src(input int p);
        int r;
        int c;
        r = p / 8;
        c = p % 8;
        return 8 * (7 - c) + ((r < 4) ? (2 * r + 2) : (2 * (r - 4) + 1));
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int p = 0; p < 64; p++) y[63-p] = x[64-ip_src(p)];
        return y;
    endfunction

    // IP^-1 is the scatter form of the same index map.
    function automatic logic [63:0] fp_perm(input logic [63:0] y);
        logic [63:0] x;
        for (int p = 0; p < 64; p++) x[64-ip_src(p)] = y[63-p];
        return x;
    endfunction

    // E expansion: group g takes bits 4g..4g+5 (1-based, wrapping 0->32, 33->1).
    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] e;
        for (int p = 0; p < 48; p++) e[47-p] = r[32-(((4 * (p / 6) + (p % 6) - 1 + 32) % 32) + 1)];
        return e;
    endfunction

    function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
        logic [5:0] sel;
        sel = 6'd63 - {b[5], b[0], b[4:1]};
        return S_TAB[n][{sel, 2'b00} +: 4];
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        x = e_expand(r) ^ k;
        for (int n = 0; n < 8; n++) s[31-4*n -: 4] = sbox(n, x[47-6*n -: 6]);
        for (int p = 0; p < 32; p++) y[31-p] = s[32-P_TAB[p]];
        return y;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [4:0]  r_rc;
    logic        r_dec;
    logic [63:0] r_out;
    logic [63:0] w_in;
    logic [63:0] w_out;
    logic        w_last;
    logic [3:0]  w_key_idx;
    logic [31:0] w_l [RPC+1];
    logic [31:0] w_r [RPC+1];

    // Unrolled Feistel chain: RPC rounds evaluated combinationally per cycle.
    assign w_l[0] = r_l;
    assign w_r[0] = r_r;
    for (genvar j = 0; j < RPC; j++) begin : g_round
        assign w_l[j+1] = w_r[j];
        assign w_r[j+1] = w_l[j] ^ f_func(w_r[j], subkey[48*j +: 48]);
    end

    // Optional initial/final permutation; output takes R||L (last swap undone).
    if (USE_IP != 0) begin : g_ip
        assign w_in  = ip_perm(in_block);
        assign w_out = fp_perm({w_r[RPC], w_l[RPC]});
    end else begin : g_raw
        assign w_in  = in_block;
        assign w_out = {w_r[RPC], w_l[RPC]};
    end

    assign w_last = ((r_rc + RPC5) == ROUNDS5);

    // Next-state decode of the IDLE/RUN/DONE handshake sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;  else w_next = IDLE;
            RUN:     if (w_last)   w_next = DONE; else w_next = RUN;
            DONE:    if (out_ready) w_next = IDLE; else w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // State register; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Datapath: latch block on accept, advance rounds in RUN, capture result on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l   <= 32'd0;
            r_r   <= 32'd0;
            r_rc  <= 5'd0;
            r_dec <= 1'b0;
            r_out <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_l   <= w_in[63:32];
                        r_r   <= w_in[31:0];
                        r_dec <= in_decrypt;
                        r_rc  <= 5'd0;
                    end
                end
                RUN: begin
                    r_l  <= w_l[RPC];
                    r_r  <= w_r[RPC];
                    r_rc <= r_rc + RPC5;
                    if (w_last) r_out <= w_out;
                end
                default: begin
                end
            endcase
        end
    end

    // Subkey index for the first round of this cycle; parked at 0 outside RUN.
    always_comb begin
        w_key_idx = 4'd0;
        if (r_state == RUN) begin
            if (r_dec) w_key_idx = 4'd15 - r_rc[3:0];
            else       w_key_idx = r_rc[3:0];
        end else begin
            w_key_idx = 4'd0;
        end
    end

    assign key_idx   = w_key_idx;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_block = r_out;

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: scoreboard bench for three engine configurations
// (16/1/IP, 16/4/IP, 8/2/raw) driven from an independent DES model.
module tb_des_round_engine;

    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                                12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                                  26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                                  51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
    localparam int U_ROUNDS [3] = '{16, 16, 8};
    localparam int U_RPC [3]    = '{1, 4, 2};
    localparam int U_IP [3]     = '{1, 1, 0};
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    logic clk = 1'b0;
    logic rst;
    logic        in_valid [3];
    logic        in_ready [3];
    logic        in_dec [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        busy [3];
    logic        cur_dec [3];
    logic [63:0] in_block [3];
    logic [63:0] out_block [3];
    logic [3:0]  key_idx [3];
    logic [191:0] subkey [3];
    logic [47:0] ks [3][16];

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q [$];
    logic [3:0]  kseq [$];

    always #5 clk = ~clk;

    des_round_engine #(.ROUNDS(16), .RPC(1), .USE_IP(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_block(in_block[0]), .in_decrypt(in_dec[0]), .key_idx(key_idx[0]),
        .subkey(subkey[0][47:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_block(out_block[0]), .busy(busy[0]));
    des_round_engine #(.ROUNDS(16), .RPC(4), .USE_IP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_block(in_block[1]), .in_decrypt(in_dec[1]), .key_idx(key_idx[1]),
        .subkey(subkey[1][191:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_block(out_block[1]), .busy(busy[1]));
    des_round_engine #(.ROUNDS(8), .RPC(2), .USE_IP(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_block(in_block[2]), .in_decrypt(in_dec[2]), .key_idx(key_idx[2]),
        .subkey(subkey[2][95:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_block(out_block[2]), .busy(busy[2]));

    // Key schedule lookup: lane j gets subkey key_idx+j (encrypt) or key_idx-j (decrypt).
    always_comb begin
        int k;
        for (int u = 0; u < 3; u++) begin
            for (int j = 0; j < 4; j++) begin
                k = cur_dec[u] ? (int'(key_idx[u]) - j) : (int'(key_idx[u]) + j);
                subkey[u][48*j +: 48] = ks[u][k & 15];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int p = 0; p < 64; p++) y[63-p] = x[64-IP_T[p]];
        return y;
    endfunction

    function automatic logic [63:0] m_fp(input logic [63:0] y);
        logic [63:0] x;
        for (int p = 0; p < 64; p++) x[64-IP_T[p]] = y[63-p];
        return x;
    endfunction

    function automatic logic [3:0] m_sbox(input int n, input int idx);
        logic [255:0] t;
        t = SB[n] >> (4 * (63 - idx));
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        for (int p = 0; p < 48; p++) e[47-p] = r[32-E_T[p]];
        e = e ^ k;
        for (int n = 0; n < 8; n++) begin
            b = e[47-6*n -: 6];
            s[31-4*n -: 4] = m_sbox(n, (2 * int'(b[5]) + int'(b[0])) * 16 + int'(b[4:1]));
        end
        for (int p = 0; p < 32; p++) y[31-p] = s[32-P_T[p]];
        return y;
    endfunction

    function automatic logic [63:0] m_des(input int u, input logic [63:0] blk, input logic dec);
        logic [63:0] v;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        v = (U_IP[u] != 0) ? m_ip(blk) : blk;
        l = v[63:32];
        r = v[31:0];
        for (int i = 0; i < U_ROUNDS[u]; i++) begin
            t = r;
            r = l ^ m_f(r, ks[u][dec ? (15 - i) : i]);
            l = t;
        end
        v = {r, l};
        return (U_IP[u] != 0) ? m_fp(v) : v;
    endfunction

    task automatic set_key(input int u, input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        for (int p = 0; p < 56; p++) cd[55-p] = key[64-PC1_T[p]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SH_T[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int p = 0; p < 48; p++) ks[u][i][47-p] = cd[56-PC2_T[p]];
        end
    endtask

    // For the 8-round unit: K[i+8] = K[i] so descending decrypt indices invert encrypt.
    task automatic set_half_keys(input int u);
        logic [63:0] k;
        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom};
            ks[u][i]   = k[47:0];
            ks[u][i+8] = k[47:0];
        end
    endtask

    function automatic logic [63:0] pack_kseq();
        logic [63:0] v;
        v = 64'd0;
        foreach (kseq[i]) v = {v[59:0], kseq[i]};
        return v;
    endfunction

    // Called at a negedge; presents the block and waits for in_ready so the next edge accepts it.
    task automatic drive_accept(input int u, input logic [63:0] blk, input logic dec, input logic [63:0] exp);
        int w;
        w = 0;
        in_block[u] = blk;
        in_dec[u]   = dec;
        in_valid[u] = 1'b1;
        cur_dec[u]  = dec;
        while (in_ready[u] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_ready", 64'(in_ready[u]), 64'd1);
        exp_q.push_back(exp);
        kseq.delete();
    endtask

    task automatic wait_result(input int u, input int stall, output int lat, output logic [63:0] got);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (out_valid[u] !== 1'b1) begin
                if (busy[u] === 1'b1) kseq.push_back(key_idx[u]);
                in_valid[u] = 1'($urandom_range(0, 1));
                in_block[u] = {$urandom, $urandom};
                in_dec[u]   = 1'($urandom_range(0, 1));
            end
        end while (out_valid[u] !== 1'b1 && lat < 60);
        in_valid[u] = 1'b0;
        check_eq("out_valid_seen", 64'(out_valid[u]), 64'd1);
        got = out_block[u];
        check_eq("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) check_eq("data", got, exp_q.pop_front());
        for (int s = 0; s < stall; s++) begin
            in_valid[u] = 1'($urandom_range(0, 1));
            in_block[u] = {$urandom, $urandom};
            @(negedge clk);
            check_eq("hold_valid", 64'(out_valid[u]), 64'd1);
            check_eq("hold_block", out_block[u], got);
            check_eq("hold_ready", 64'(in_ready[u]), 64'd0);
        end
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        check_eq("idle_ready", 64'(in_ready[u]), 64'd1);
        check_eq("idle_valid", 64'(out_valid[u]), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        logic [63:0] got;
        logic [63:0] blk;
        logic [63:0] exp;
        logic dec;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_dec[u] = 1'b0; out_ready[u] = 1'b0;
            cur_dec[u] = 1'b0; in_block[u] = 64'd0;
        end
        set_key(0, KEY);
        set_key(1, KEY);
        set_half_keys(2);
        rst = 1'b1;
        #3 rst = 1'b0;
        #20;
        check_eq("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("rst_busy", 64'(busy[0]), 64'd0);
        check_eq("rst_out_block", out_block[0], 64'd0);
        check_eq("rst_key_idx", 64'(key_idx[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Known-answer vectors, default configuration; accept on first edge after release.
        drive_accept(0, PT, 1'b0, CT);
        wait_result(0, 0, lat, got);
        check_eq("enc_lat", 64'(lat), 64'd17);
        check_eq("enc_kidx", pack_kseq(), 64'h0123456789ABCDEF);
        drive_accept(0, CT, 1'b1, PT);
        wait_result(0, 0, lat, got);
        check_eq("dec_lat", 64'(lat), 64'd17);
        check_eq("dec_kidx", pack_kseq(), 64'hFEDCBA9876543210);

        // Four rounds per clock.
        drive_accept(1, PT, 1'b0, CT);
        wait_result(1, 0, lat, got);
        check_eq("rpc4_enc_lat", 64'(lat), 64'd5);
        check_eq("rpc4_enc_kidx", pack_kseq(), 64'h048C);
        drive_accept(1, CT, 1'b1, PT);
        wait_result(1, 0, lat, got);
        check_eq("rpc4_dec_lat", 64'(lat), 64'd5);
        check_eq("rpc4_dec_kidx", pack_kseq(), 64'hFB73);

        // Backpressure: result held for 10 cycles with in_valid pulses.
        drive_accept(0, PT, 1'b0, CT);
        wait_result(0, 10, lat, got);

        // Reset during RUN cycle 8 discards the block.
        drive_accept(0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("mid_rst_busy", 64'(busy[0]), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
        check_eq("mid_rst_out_block", out_block[0], 64'd0);
        check_eq("mid_rst_key_idx", 64'(key_idx[0]), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1 || busy[0] === 1'b1) seen++;
        end
        check_eq("post_rst_quiet", 64'(seen), 64'd0);
        drive_accept(0, PT, 1'b0, CT);
        wait_result(0, 0, lat, got);
        check_eq("post_rst_lat", 64'(lat), 64'd17);

        // Random blocks, keys, modes and backpressure, each followed by a round trip.
        for (int u = 0; u < 3; u++) begin
            for (int it = 0; it < ((u == 0) ? 200 : 150); it++) begin
                if (it % 20 == 0) begin
                    if (u < 2) set_key(u, {$urandom, $urandom});
                    else       set_half_keys(u);
                end
                blk = {$urandom, $urandom};
                dec = 1'($urandom_range(0, 1));
                exp = m_des(u, blk, dec);
                drive_accept(u, blk, dec, exp);
                wait_result(u, $urandom_range(0, 3), lat, got);
                check_eq("rand_lat", 64'(lat), 64'(U_ROUNDS[u] / U_RPC[u] + 1));
                drive_accept(u, got, ~dec, blk);
                wait_result(u, $urandom_range(0, 3), lat, got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 16, meaning the number of Feistel rounds per block; legal values are 1..16.
REQ-002 The block SHALL have parameter RPC, default 1, meaning rounds per clock (unroll factor); legal values are 1, 2, 4; ROUNDS SHALL be a multiple of RPC.
REQ-003 The block SHALL have parameter USE_IP, default 1, meaning apply the FIPS 46-3 IP on input and IP^-1 on output; 0 means in/out blocks are raw L||R halves.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  block offered.
REQ-007 in_ready  out  1  block accepted on the cycle in_valid&in_ready.
REQ-008 in_block  in  64  plaintext/ciphertext; bit 63 is DES bit 1.
REQ-009 in_decrypt  in  1  sampled with in_block; 1 means use subkeys in descending order.
REQ-010 key_idx  out  4  index of the subkey for the first round computed this cycle.
REQ-011 subkey  in  48*RPC  lane j (bits 48j+47:48j) is the subkey for round key_idx+j (encrypt) or key_idx-j (decrypt); combinational from the key schedule, same cycle.
REQ-012 out_valid  out  1  result held.
REQ-013 out_ready  in  1  result consumed on the cycle out_valid&out_ready.
REQ-014 out_block  out  64  result.
REQ-015 busy  out  1  high in RUN or DONE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 IDLE->RUN on in_valid: latch L,R = halves of IP(in_block) (or in_block when USE_IP=0), latch mode, round counter rc=0.
REQ-018 Each RUN cycle SHALL apply RPC rounds in a combinational chain: L'=R, R'=L^f(R,K), with f = E expansion, XOR with subkey, S1..S8, P permutation per FIPS 46-3; rc += RPC.
REQ-019 key_idx SHALL equal rc in encrypt mode and 15-rc in decrypt mode; it SHALL be 0 in IDLE and DONE.
REQ-020 When rc+RPC reaches ROUNDS, the state SHALL go RUN->DONE and store out_block = IP^-1(R||L) (final swap undone, preswap per DES), or R||L when USE_IP=0.
REQ-021 Latency from accept cycle to first out_valid cycle SHALL be ROUNDS/RPC+1 cycles (17 for defaults).
REQ-022 DONE SHALL hold out_block and out_valid stable until out_ready; DONE->IDLE on out_ready.
REQ-023 Throughput SHALL be one block per ROUNDS/RPC+2 cycles; there is no accept in the DONE->IDLE cycle (no bypass).
REQ-024 in_valid in RUN/DONE SHALL be ignored; in_block and in_decrypt changes after acceptance SHALL have no effect.
REQ-025 Encrypt then decrypt of any block with the same subkey set and ROUNDS SHALL return the original block.
REQ-026 out_block SHALL be registered; in_ready, out_valid, busy SHALL be decoded directly from state registers.

Reset
REQ-027 rst low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, busy=0, out_block=0, key_idx=0, rc=0, L=R=0, regardless of state.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the block; no out_valid SHALL follow release without a new accept.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-030 Defaults, key 133457799BBCDFF1 schedule, encrypt in_block 0123456789ABCDEF -> out_block 85E813540F0AB405 exactly 17 cycles after accept.
REQ-031 Same key, decrypt 85E813540F0AB405 -> 0123456789ABCDEF; key_idx sequence observed is 15,14,...,0.
REQ-032 RPC=4: same vectors as REQ-030/031 -> identical results, out_valid 5 cycles after accept, key_idx 0,4,8,12.
REQ-033 out_ready held low 10 cycles in DONE -> out_block/out_valid stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-034 rst pulsed low at RUN cycle 8 -> outputs at reset values at once, no out_valid later; a new block then completes with correct ciphertext.
REQ-035 Random 1000 blocks, random keys/mode/backpressure, ROUNDS in {8,16}, USE_IP in {0,1} -> match reference model; encrypt/decrypt round trip identity.
